// File: rtl/wash_pkg.sv
// Shared types and constants for the wash program sequencer: state and mode
// enums, the BCD pair type, the blank level code and the phase bar patterns.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WASH,
        ST_DRAIN,
        ST_SPIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_QUICK,
        MODE_NORMAL,
        MODE_HEAVY,
        MODE_RINSE
    } mode_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam logic [3:0] BLANK     = 4'd11;
    localparam logic [7:0] LED_IDLE  = 8'b0000_0001;
    localparam logic [7:0] LED_FILL  = 8'b0000_0011;
    localparam logic [7:0] LED_WASH  = 8'b0000_1111;
    localparam logic [7:0] LED_DRAIN = 8'b0011_1111;
    localparam logic [7:0] LED_SPIN  = 8'b0111_1111;
    localparam logic [7:0] LED_DONE  = 8'b1111_1111;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens = 4'((v / 10) % 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] led_pattern(input state_e s);
        case (s)
            ST_IDLE:  return LED_IDLE;
            ST_FILL:  return LED_FILL;
            ST_WASH:  return LED_WASH;
            ST_DRAIN: return LED_DRAIN;
            ST_SPIN:  return LED_SPIN;
            ST_DONE:  return LED_DONE;
            default:  return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/wash_bcd_down2.sv
// Two-digit BCD down counter: synchronous load wins over decrement, the
// decrement borrows x0 -> (x-1)9 and holds at 00.
module wash_bcd_down2
    import wash_pkg::*;
#(
    parameter bcd2_t RST_VAL = '0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  bcd2_t load_val_i,
    input  logic  dec_i,
    output bcd2_t cnt_o,
    output logic  zero_o
);

    bcd2_t cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            if (cnt_q.ones == 4'd0) begin
                cnt_d.ones = 4'd9;
                cnt_d.tens = cnt_q.tens - 4'd1;
            end else begin
                cnt_d.ones = cnt_q.ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= RST_VAL;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_seq.sv
// Washing-machine program sequencer FILL -> WASH -> DRAIN -> SPIN with pause and
// a BCD countdown of remaining seconds. Optional door interlock: DOOR_LOCK_EN.
module wash_seq
    import wash_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned LEVEL_MAX = 5,
    parameter int unsigned SPIN_S    = 10,
    parameter int unsigned WASH_S0   = 20,
    parameter int unsigned WASH_S1   = 40,
    parameter int unsigned WASH_S2   = 60,
    parameter int unsigned WASH_S3   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
`ifdef DOOR_LOCK_EN
    input  logic       door_open,
    output logic       door_lock,
`endif
    output logic [3:0] rem_tens,
    output logic [3:0] rem_ones,
    output logic [3:0] level,
    output logic [7:0] phase_led,
    output logic       busy,
    output logic       paused,
    output logic       done
);

    localparam int unsigned PW     = $clog2(TICK_DIV);
    localparam int unsigned BASE_S = 2 * LEVEL_MAX + SPIN_S;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    LEVEL_TOP  = 4'(LEVEL_MAX);
    localparam logic [6:0]    SPIN_LEN   = 7'(SPIN_S);
    localparam bcd2_t TOT_BCD0 = to_bcd2(BASE_S + WASH_S0);
    localparam bcd2_t TOT_BCD1 = to_bcd2(BASE_S + WASH_S1);
    localparam bcd2_t TOT_BCD2 = to_bcd2(BASE_S + WASH_S2);
    localparam bcd2_t TOT_BCD3 = to_bcd2(BASE_S + WASH_S3);

    if (TICK_DIV < 2 || LEVEL_MAX < 1 || LEVEL_MAX > 9 || SPIN_S < 1 || SPIN_S > 99 ||
        WASH_S0 < 1 || WASH_S1 < 1 || WASH_S2 < 1 || WASH_S3 < 1 ||
        BASE_S + WASH_S0 > 99 || BASE_S + WASH_S1 > 99 ||
        BASE_S + WASH_S2 > 99 || BASE_S + WASH_S3 > 99) begin : g_param_check
        $error("wash_seq: parameter set out of range");
    end

    function automatic bcd2_t total_bcd(input mode_e m);
        case (m)
            MODE_QUICK:  return TOT_BCD0;
            MODE_NORMAL: return TOT_BCD1;
            MODE_HEAVY:  return TOT_BCD2;
            default:     return TOT_BCD3;
        endcase
    endfunction

    function automatic logic [6:0] wash_len(input mode_e m);
        case (m)
            MODE_QUICK:  return 7'(WASH_S0);
            MODE_NORMAL: return 7'(WASH_S1);
            MODE_HEAVY:  return 7'(WASH_S2);
            default:     return 7'(WASH_S3);
        endcase
    endfunction

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          paused_q, paused_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    level_q, level_d;
    logic [6:0]    phase_q, phase_d;
    logic [7:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic  cnt_load, cnt_dec, rem_zero;
    bcd2_t cnt_val, rem_cnt;
    logic  door_open_s, busy_s, run, tick, start_ok;

`ifdef DOOR_LOCK_EN
    assign door_open_s = door_open;
    assign door_lock   = busy_q;
`else
    assign door_open_s = 1'b0;
`endif

    // An open door stalls the second counter exactly like pause, without touching paused.
    assign busy_s   = state_q inside {ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN};
    assign run      = busy_s && !paused_q && !door_open_s;
    assign tick     = run && (presc_q == PRESC_LAST);
    assign start_ok = start && !door_open_s && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        paused_d = paused_q;
        presc_d  = presc_q;
        level_d  = level_q;
        phase_d  = phase_q;
        cnt_load = 1'b0;
        cnt_val  = total_bcd(mode_e'(mode));
        cnt_dec  = 1'b0;
        if (start_ok) begin
            state_d  = ST_FILL;
            mode_d   = mode_e'(mode);
            paused_d = 1'b0;
            presc_d  = '0;
            level_d  = 4'd0;
            cnt_load = 1'b1;
        end else begin
            // IDLE keeps reloading the counter so the digits preview the selected program.
            if (state_q == ST_IDLE) cnt_load = 1'b1;
            if (run) presc_d = tick ? '0 : presc_q + 1'b1;
            if (busy_s && pause) paused_d = !paused_q;
            if (tick) begin
                cnt_dec = !rem_zero;
                case (state_q)
                    ST_FILL: begin
                        level_d = level_q + 4'd1;
                        if (level_q + 4'd1 == LEVEL_TOP) begin
                            state_d = ST_WASH;
                            phase_d = wash_len(mode_q);
                        end
                    end
                    ST_WASH: begin
                        phase_d = phase_q - 7'd1;
                        if (phase_q == 7'd1) state_d = ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        level_d = level_q - 4'd1;
                        if (level_q == 4'd1) begin
                            state_d = ST_SPIN;
                            phase_d = SPIN_LEN;
                        end
                    end
                    ST_SPIN: begin
                        phase_d = phase_q - 7'd1;
                        if (phase_q == 7'd1) begin
                            state_d  = ST_DONE;
                            paused_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        led_d  = led_pattern(state_d) | {paused_d | (busy_s & door_open_s), 7'b0};
        busy_d = state_d inside {ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN};
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_QUICK;
            paused_q <= 1'b0;
            presc_q  <= '0;
            level_q  <= BLANK;
            phase_q  <= 7'd0;
            led_q    <= LED_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            presc_q  <= presc_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    wash_bcd_down2 #(
        .RST_VAL(TOT_BCD0)
    ) u_rem (
        .clk_i     (clk),
        .rst_ni    (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (cnt_dec),
        .cnt_o     (rem_cnt),
        .zero_o    (rem_zero)
    );

    assign rem_tens  = rem_cnt.tens;
    assign rem_ones  = rem_cnt.ones;
    assign level     = level_q;
    assign phase_led = led_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign done      = done_q;

endmodule

// File: tb/tb_wash_seq.sv
// Bench for wash_seq: an elapsed-seconds model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wash_seq;

    localparam int TICK_DIV = 4;
    localparam int L        = 5;
    localparam int S        = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       door_open = 1'b0;
    logic [3:0] rem_tens, rem_ones, level;
    logic [7:0] phase_led;
    logic       busy, paused, done;
`ifdef DOOR_LOCK_EN
    logic       door_lock;
`endif

    int vectors     = 0;
    int miscompares = 0;

    wash_seq #(
        .TICK_DIV(TICK_DIV), .LEVEL_MAX(L), .SPIN_S(S),
        .WASH_S0(20), .WASH_S1(40), .WASH_S2(60), .WASH_S3(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .mode     (mode),
`ifdef DOOR_LOCK_EN
        .door_open(door_open),
        .door_lock(door_lock),
`endif
        .rem_tens (rem_tens),
        .rem_ones (rem_ones),
        .level    (level),
        .phase_led(phase_led),
        .busy     (busy),
        .paused   (paused),
        .done     (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic int wash_s(input int m);
        case (m)
            0:       return 20;
            1:       return 40;
            2:       return 60;
            default: return 10;
        endcase
    endfunction

    function automatic int tot(input int m);
        return 2 * L + S + wash_s(m);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: program progress as elapsed seconds since start
    bit m_active  = 1'b0;
    bit m_done    = 1'b0;
    bit m_paused  = 1'b0;
    bit m_door    = 1'b0;
    int m_e       = 0;
    int m_presc   = 0;
    int m_mode    = 0;
    int m_preview = 40;

    always @(posedge clk or negedge rst) begin : model
        bit a, d, p, dr, tk;
        int e, pr, md, pv;
        if (!rst) begin
            m_active  <= 1'b0;
            m_done    <= 1'b0;
            m_paused  <= 1'b0;
            m_door    <= 1'b0;
            m_e       <= 0;
            m_presc   <= 0;
            m_preview <= tot(0);
        end else begin
            a = m_active; d = m_done; p = m_paused; dr = 1'b0;
            e = m_e; pr = m_presc; md = m_mode; pv = m_preview;
            if (start && !a && !door_open) begin
                a = 1'b1; d = 1'b0; p = 1'b0; e = 0; pr = 0; md = int'(mode);
            end else begin
                if (!a && !d) pv = tot(int'(mode));
                if (a) begin
                    dr = door_open;
                    tk = 1'b0;
                    if (!p && !door_open) begin
                        if (pr == TICK_DIV - 1) begin tk = 1'b1; pr = 0; end
                        else pr = pr + 1;
                    end
                    if (pause) p = !p;
                    if (tk) begin
                        e = e + 1;
                        if (e == tot(md)) begin a = 1'b0; d = 1'b1; p = 1'b0; end
                    end
                end
            end
            m_active <= a; m_done <= d; m_paused <= p; m_door <= dr;
            m_e <= e; m_presc <= pr; m_mode <= md; m_preview <= pv;
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin : compare
        int r, w;
        logic [7:0] e_lvl, e_led;
        logic e_busy, e_done;
        if (m_active) begin
            w = wash_s(m_mode);
            r = tot(m_mode) - m_e;
            if (m_e < L)              begin e_lvl = 8'(m_e);             e_led = 8'h03; end
            else if (m_e < L + w)     begin e_lvl = 8'(L);               e_led = 8'h0F; end
            else if (m_e < 2 * L + w) begin e_lvl = 8'(2 * L + w - m_e); e_led = 8'h3F; end
            else                      begin e_lvl = 8'd0;                e_led = 8'h7F; end
            if (m_paused || m_door) e_led[7] = 1'b1;
            e_busy = 1'b1; e_done = 1'b0;
        end else if (m_done) begin
            r = 0; e_lvl = 8'd0; e_led = 8'hFF; e_busy = 1'b0; e_done = 1'b1;
        end else begin
            r = m_preview; e_lvl = 8'd11; e_led = 8'h01; e_busy = 1'b0; e_done = 1'b0;
        end
        check8("m_rem_tens", 8'(rem_tens), 8'(r / 10));
        check8("m_rem_ones", 8'(rem_ones), 8'(r % 10));
        check8("m_level", 8'(level), e_lvl);
        check8("m_phase_led", phase_led, e_led);
        check8("m_busy", 8'(busy), 8'(e_busy));
        check8("m_paused", 8'(paused), 8'(m_paused));
        check8("m_done", 8'(done), 8'(e_done));
`ifdef DOOR_LOCK_EN
        check8("m_door_lock", 8'(door_lock), 8'(e_busy));
`endif
    end

    // driver tasks (called at a falling edge, return one cycle later)
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        check8("rst_rem_tens", 8'(rem_tens), 8'd4);
        check8("rst_rem_ones", 8'(rem_ones), 8'd0);
        check8("rst_level", 8'(level), 8'd11);
        check8("rst_led", phase_led, 8'h01);
        check8("rst_busy", 8'(busy), 8'd0);
        check8("rst_done", 8'(done), 8'd0);
        check8("rst_paused", 8'(paused), 8'd0);
        wait_clks(1);
        rst = 1'b1;
        wait_clks(2);

        // IDLE preview follows the mode input
        mode = 2'd1;
        wait_clks(1);
        check8("preview_m1_tens", 8'(rem_tens), 8'd6);
        check8("preview_m1_ones", 8'(rem_ones), 8'd0);
        mode = 2'd0;
        wait_clks(1);
        check8("preview_m0_tens", 8'(rem_tens), 8'd4);

        // mode 0 full run: 40 ticks of 4 clocks
        pulse_start(2'd0);
        check8("t1_fill_led", phase_led, 8'h03);
        check8("t1_fill_level", 8'(level), 8'd0);
        check8("t1_busy", 8'(busy), 8'd1);
        wait_clks(4);
        check8("t1_rem39_tens", 8'(rem_tens), 8'd3);
        check8("t1_rem39_ones", 8'(rem_ones), 8'd9);
        check8("t1_level1", 8'(level), 8'd1);
        wait_clks(16);
        check8("t1_wash_led", phase_led, 8'h0F);
        check8("t1_wash_level", 8'(level), 8'd5);
        wait_clks(140);
        check8("t1_done", 8'(done), 8'd1);
        check8("t1_done_rem", {rem_tens, rem_ones}, 8'h00);
        check8("t1_done_led", phase_led, 8'hFF);

        // mode 2 run; mode change and start while busy must be ignored
        pulse_start(2'd2);
        wait_clks(10);
        pulse_start(2'd1);
        wait_clks(269);
        check8("t2_rem10", {rem_tens, rem_ones}, 8'h10);
        wait_clks(4);
        check8("t2_rem09", {rem_tens, rem_ones}, 8'h09);
        wait_clks(36);
        check8("t2_done", 8'(done), 8'd1);
        check8("t2_rem00", {rem_tens, rem_ones}, 8'h00);
        wait_clks(8);
        check8("t2_no_wrap", {rem_tens, rem_ones}, 8'h00);

        // pause two clocks into a second during WASH
        pulse_start(2'd0);
        wait_clks(25);
        pulse_pause();
        wait_clks(50);
        check8("t3_frozen_rem", {rem_tens, rem_ones}, 8'h34);
        check8("t3_paused", 8'(paused), 8'd1);
        check8("t3_led", phase_led, 8'h8F);
        pulse_pause();
        check8("t3_resumed", 8'(paused), 8'd0);
        wait_clks(1);
        check8("t3_rem_hold", {rem_tens, rem_ones}, 8'h34);
        wait_clks(1);
        check8("t3_rem_tick", {rem_tens, rem_ones}, 8'h33);

        // asynchronous reset in DRAIN
        wait_clks(76);
        check8("t5_drain_led", phase_led, 8'h3F);
        check8("t5_drain_level", 8'(level), 8'd4);
        #2 rst = 1'b0;
        #1;
        check8("t5_arst_rem", {rem_tens, rem_ones}, 8'h40);
        check8("t5_arst_level", 8'(level), 8'd11);
        check8("t5_arst_led", phase_led, 8'h01);
        check8("t5_arst_busy", 8'(busy), 8'd0);
        wait_clks(2);
        rst = 1'b1;
        wait_clks(1);
        pulse_start(2'd3);
        wait_clks(120);
        check8("t5_rinse_done", 8'(done), 8'd1);
        check8("t5_rinse_rem", {rem_tens, rem_ones}, 8'h00);

`ifdef DOOR_LOCK_EN
        // door opened in SPIN stalls the countdown; start with door open is ignored
        pulse_start(2'd3);
        wait_clks(85);
        door_open = 1'b1;
        wait_clks(20);
        check8("t6_door_rem", {rem_tens, rem_ones}, 8'h09);
        check8("t6_door_lock", 8'(door_lock), 8'd1);
        check8("t6_door_led", phase_led, 8'hFF);
        check8("t6_door_busy", 8'(busy), 8'd1);
        door_open = 1'b0;
        wait_clks(35);
        check8("t6_done", 8'(done), 8'd1);
        door_open = 1'b1;
        pulse_start(2'd0);
        wait_clks(2);
        check8("t6_start_blocked", 8'(done), 8'd1);
        check8("t6_lock_off", 8'(door_lock), 8'd0);
        door_open = 1'b0;
        wait_clks(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wash_seq.md
Name: wash_seq

Overview:
Parametrised washing-machine program sequencer; successor to the single-program wash controller.
Runs FILL -> WASH -> DRAIN -> SPIN with a selectable wash program, pause/resume and a two-digit BCD countdown of total remaining seconds.
Drives the existing 4-digit scan driver (water-level digit plus two countdown digits) and the 8-LED phase bar.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (min 2)
LEVEL_MAX, 5, water level reached in FILL, 1..9; FILL and DRAIN each last LEVEL_MAX s
SPIN_S, 10, SPIN duration in s, 1..99
WASH_S0, 20, WASH duration for mode 0 (quick)
WASH_S1, 40, WASH duration for mode 1 (normal)
WASH_S2, 60, WASH duration for mode 2 (heavy)
WASH_S3, 10, WASH duration for mode 3 (rinse)
Constraint, checked by elaboration assertion: 2*LEVEL_MAX + SPIN_S + WASH_Sx <= 99 for every mode.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; starts a cycle from IDLE or DONE
pause  in  1  1-cycle pulse; toggles pause while running
mode  in  2  wash program select; sampled only on an accepted start
rem_tens  out  4  BCD tens of remaining seconds
rem_ones  out  4  BCD ones of remaining seconds
level  out  4  water level 0..LEVEL_MAX; 4'd11 = blank
phase_led  out  8  phase bar
busy  out  1  high in FILL, WASH, DRAIN, SPIN
paused  out  1  pause active
done  out  1  high in DONE

Behaviour:
- Reset (async, rst=0): state IDLE, paused=0, prescaler=0, level=11 (blank), phase_led=8'b0000_0001, busy=0, done=0. rem digits show the mode-0 total.
- IDLE: rem_tens/rem_ones continuously show the total for the current mode input (2*LEVEL_MAX+SPIN_S+WASH_Sx) as a live preview. level is blank.
- Accepted start (in IDLE or DONE):
  - latch mode;
  - load the BCD counter with the total;
  - prescaler=0, level=0, paused=0;
  - next cycle: state FILL.
- start in any other state is ignored.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 only while busy && !paused.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - While paused the prescaler holds its value; resume continues the partial second.
- On each tick:
  - Remaining count decrements by 1 with BCD borrow (x0 -> (x-1)9).
  - The phase counter decrements.
- Phase actions per tick:
  - FILL: level+1; on the tick where level reaches LEVEL_MAX, go to WASH with phase counter = latched WASH_Sx.
  - WASH: on the tick where the phase counter reaches 0, go to DRAIN.
  - DRAIN: level-1; on the tick where level reaches 0, go to SPIN with phase counter = SPIN_S.
  - SPIN: on the tick where the phase counter reaches 0, go to DONE. Remaining is exactly 00 on this tick.
- DONE: rem=00, level=0, done=1, busy=0. Held until start or reset.
- phase_led:
  - IDLE 0000_0001
  - FILL 0000_0011
  - WASH 0000_1111
  - DRAIN 0011_1111
  - SPIN 0111_1111
  - DONE 1111_1111
  - While paused, bit 7 is forced 1.
- Pause:
  - A pause pulse while busy toggles paused.
  - A pause pulse in IDLE/DONE is ignored.
  - If pause and tick coincide, the tick is applied, then paused=1.
  - If pause and start coincide in IDLE/DONE, start wins and paused=0.
- mode changes while busy have no effect on the running program.
- Reset mid-cycle returns immediately to the reset values. No partial state is retained.
- All outputs are registered; outputs reflect a state change one cycle after the causing tick or pulse.

Optional Feature:
DOOR_LOCK_EN — when defined, adds input door_open and output door_lock.
- door_lock=1 whenever busy.
- door_open=1 while busy holds the prescaler (acts as pause; the paused output is unaffected) and forces phase_led[7]=1.
- start is ignored while door_open=1.
When DOOR_LOCK_EN is undefined, neither port exists and behaviour is exactly as above.

Decomposition:
Package wash_pkg holds:
- state enum (IDLE, FILL, WASH, DRAIN, SPIN, DONE);
- mode enum;
- BLANK=4'd11;
- the six phase_led patterns;
- the 2-digit BCD type.

One sub-module, wash_bcd_down2: two-digit BCD down counter with synchronous load, decrement enable and zero flag. It is instantiated once for the remaining count.

Test Plan:
1. TICK_DIV=4, LEVEL_MAX=5, SPIN_S=10, mode=0, start -> FILL at +1 clk; rem 40 -> 39 after 4 clk; level 1..5; WASH after 5 ticks; DONE after 40 ticks (160 clk), done=1, rem=00, phase_led=FF.
2. Mode 2 start; at rem=10 observe next tick -> rem_tens=0, rem_ones=9 (BCD borrow); at 00 state is DONE, not wrap to 99.
3. Pause pulse 2 clk into a tick during WASH -> rem frozen, paused=1, led[7]=1 for 50 clk; second pause -> next tick after 2 more clk.
4. In IDLE, mode 0->1 -> preview 40->60; during a run, change mode -> WASH length unchanged; start during run ignored.
5. rst=0 asserted mid-DRAIN asynchronously (between clk edges) -> outputs at reset values without a clock edge; subsequent start runs a full cycle.
6. DOOR_LOCK_EN: door_open=1 in SPIN -> countdown holds, door_lock=1; start with door_open=1 in DONE -> ignored.
